serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor built around a single full-subtractor cell plus a registered borrow. It is the inverse companion to the team's combinational full adder.
- It computes a - b - bin LSB-first, one bit per clock, with a start/busy/done handshake.
- It sits beside the adder datapath as a low-area arithmetic unit for the same designs.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request side; the slave (the subtractor) returns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered borrow.
// Results appear only on completion; every output comes straight from a flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  sif
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic             br_reg, br_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             bout_reg, bout_next;

    // Full-subtractor cell on the current LSBs and the running borrow.
    logic             bit_d;
    logic             bit_borrow;
    logic [WIDTH-1:0] sr_shift;

    assign bit_d      = sa_reg[0] ^ sb_reg[0] ^ br_reg;
    assign bit_borrow = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);

    // Result register shifts right; the fresh bit enters at the MSB so that
    // after WIDTH steps bit i sits at position i.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sr_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign sr_shift[gi] = bit_d;
            end else begin : g_low
                assign sr_shift[gi] = sr_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            sr_reg    <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            sr_reg    <= sr_next;
            br_reg    <= br_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            diff_reg  <= diff_next;
            bout_reg  <= bout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        sr_next    = sr_reg;
        br_next    = br_reg;
        cnt_next   = cnt_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        diff_next  = diff_reg;
        bout_next  = bout_reg;

        case (state_reg)
            IDLE: begin
                if (sif.start) begin
                    state_next = RUN;
                    sa_next    = sif.a;
                    sb_next    = sif.b;
                    br_next    = sif.bin;
                    cnt_next   = '0;
                    sr_next    = '0;
                    busy_next  = 1'b1;
                end
            end
            RUN: begin
                sa_next  = sa_reg >> 1;
                sb_next  = sb_reg >> 1;
                sr_next  = sr_shift;
                br_next  = bit_borrow;
                cnt_next = cnt_reg + CNT_W'(1);
                // Publish on the edge that consumes the last bit, so diff never shows partials.
                if (cnt_reg == LAST_BIT) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    diff_next  = sr_shift;
                    bout_next  = bit_borrow;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign sif.busy = busy_reg;
    assign sif.done = done_reg;
    assign sif.diff = diff_reg;
    assign sif.bout = bout_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench: expected {bout,diff} queued at launch, checked on each done pulse.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) sif8 ();
    serial_subtractor_if #(.WIDTH(4)) sif4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .sif(sif8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .sif(sif4));

    int total = 0;
    int bad   = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] e8;
    logic [4:0] e4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitors: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && sif8.done) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("diff8", 32'(sif8.diff), 32'(e8[7:0]));
                chk("bout8", 32'(sif8.bout), 32'(e8[8]));
                $display("W8 done diff=0x%02h bout=%0b", sif8.diff, sif8.bout);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && sif4.done) begin
            if (q4.size() == 0) begin
                chk("done4_unexpected", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                chk("diff4", 32'(sif4.diff), 32'(e4[3:0]));
                chk("bout4", 32'(sif4.bout), 32'(e4[4]));
            end
        end
    end

    // Drive one request for one edge (called at a negedge) and queue its result.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit hold);
        q8.push_back({1'b0, a} - {1'b0, b} - 9'(bin));
        sif8.start = 1'b1;
        sif8.a     = a;
        sif8.b     = b;
        sif8.bin   = bin;
        @(negedge clk);
        if (!hold) sif8.start = 1'b0;
    endtask

    // Count negedges until done is seen (bounded), tallying busy cycles on the way.
    task automatic wait8(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!sif8.done && n < 40) begin
            if (sif8.busy) nbusy++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int n;
        int nbusy;
        q4.push_back({1'b0, a} - {1'b0, b} - 5'(bin));
        sif4.start = 1'b1;
        sif4.a     = a;
        sif4.b     = b;
        sif4.bin   = bin;
        @(negedge clk);
        sif4.start = 1'b0;
        n = 1;
        nbusy = 0;
        while (!sif4.done && n < 40) begin
            if (sif4.busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk("lat4", 32'(n), 32'd5);
        chk("busy4", 32'(nbusy), 32'd4);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int n;
        int nbusy;
        launch8(a, b, bin, 1'b0);
        wait8(n, nbusy);
        chk("lat8", 32'(n + 1), 32'd9);
        chk("busy8", 32'(nbusy), 32'd8);
        $display("W8 op a=0x%02h b=0x%02h bin=%0b latency=%0d", a, b, bin, n + 1);
    endtask

    initial begin
        int n;
        int nbusy;
        sif8.start = 1'b0; sif8.a = '0; sif8.b = '0; sif8.bin = 1'b0;
        sif4.start = 1'b0; sif4.a = '0; sif4.b = '0; sif4.bin = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(sif8.busy), 32'd0);
        chk("rst_done", 32'(sif8.done), 32'd0);
        chk("rst_diff", 32'(sif8.diff), 32'd0);
        chk("rst_bout", 32'(sif8.bout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operations, including full-borrow corners.
        op8(8'h5A, 8'h3C, 1'b0);
        op8(8'h00, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        op8(8'h00, 8'hFF, 1'b1);

        // Exhaustive WIDTH=4 sweep, issued back-to-back.
        for (int i = 0; i < 512; i++) begin
            op4(4'(i), 4'(i >> 4), 1'(i >> 8));
        end

        // Start while busy is ignored.
        launch8(8'h10, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        sif8.start = 1'b1; sif8.a = 8'hAA; sif8.b = 8'h55;
        @(negedge clk);
        sif8.start = 1'b0;
        wait8(n, nbusy);
        chk("lat8_ign", 32'(n + 3), 32'd9);
        repeat (12) @(negedge clk);
        chk("q8_ign_empty", 32'(q8.size()), 32'd0);
        $display("W8 start-while-busy ignored check done");

        // Asynchronous reset mid-operation: nothing queued, so any later done is flagged.
        sif8.start = 1'b1; sif8.a = 8'h80; sif8.b = 8'h01; sif8.bin = 1'b0;
        @(negedge clk);
        sif8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(sif8.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(sif8.busy), 32'd0);
        chk("arst_done", 32'(sif8.done), 32'd0);
        chk("arst_diff", 32'(sif8.diff), 32'd0);
        chk("arst_bout", 32'(sif8.bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("arst_no_done", 32'(sif8.busy), 32'd0);
        $display("W8 mid-op reset check done");

        // Back-to-back with start held high.
        launch8(8'h03, 8'h01, 1'b0, 1'b1);
        wait8(n, nbusy);
        chk("b2b_lat1", 32'(n + 1), 32'd9);
        q8.push_back({1'b0, 8'h01} - {1'b0, 8'h03});
        sif8.a = 8'h01; sif8.b = 8'h03;
        repeat (4) @(negedge clk);
        chk("b2b_hold", 32'(sif8.diff), 32'h02);
        wait8(n, nbusy);
        chk("b2b_gap", 32'(n + 4), 32'd9);
        sif8.start = 1'b0;
        repeat (12) @(negedge clk);
        $display("W8 back-to-back check done");

        chk("q8_empty", 32'(q8.size()), 32'd0);
        chk("q4_empty", 32'(q4.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
